// File: rtl/burst_mem_reader_pkg.sv
// Shared definitions for the memory read/write engines.
// Holds the common FSM state encoding (the write path uses the same names)
// and the default memory geometry.
package burst_mem_reader_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_ACTIVE = 3'b001,
        ST_DONE   = 3'b010
    } state_e;

endpackage

// File: rtl/burst_mem_reader_rd_skid_buffer.sv
// rd_skid_buffer: 2-entry valid/ready FIFO that catches read data returning
// from the memory one cycle after the read strobe.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   push_i, push_data_i   write one entry (caller guarantees room)
//   pop_i                 remove head entry (caller guarantees non-empty)
//   occ_o                 number of entries held (0..2)
//   valid_o               buffer non-empty
//   head_o                oldest entry; all-zero after reset
module rd_skid_buffer #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [1:0]       occ_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] head_o
);

    logic [1:0][WIDTH-1:0] ent_q;
    logic                  rd_ptr_q;
    logic                  wr_ptr_q;
    logic [1:0]            cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q    <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) begin
                ent_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign occ_o   = cnt_q;
    assign valid_o = (cnt_q != 2'd0);
    assign head_o  = ent_q[rd_ptr_q];

endmodule

// File: rtl/burst_mem_reader.sv
// burst_mem_reader: reads a burst of consecutive words from a 1-cycle-latency
// synchronous memory and streams them out on a valid/ready interface,
// tagging the final beat with out_last.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   start, start_addr, burst_len       burst command, sampled in IDLE only
//   busy, done                         FSM status (done = 1-cycle pulse)
//   mem_rd_en, mem_rd_addr, mem_rd_data  memory read port (data 1 cycle later)
//   out_valid, out_ready, out_data, out_last  output stream
module burst_mem_reader
    import burst_mem_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   burst_len,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   issued_q;
    logic                  infl_q;       // read issued last cycle, data on mem_rd_data now
    logic                  infl_last_q;  // that read was the final word of the burst

    logic [1:0]            occ;
    logic                  buf_valid;
    logic [DATA_WIDTH:0]   head;
    logic                  pop;
    logic [2:0]            pend;
    logic                  room;
    logic                  is_last_rd;

    assign pop  = buf_valid && out_ready;

    // Credit check: entries held plus the read in flight, less the one
    // leaving this cycle, must stay below the buffer depth before issuing.
    assign pend = {1'b0, occ} + {2'b00, infl_q};
    assign room = pend < (3'd2 + {2'b00, pop});

    assign is_last_rd  = (issued_q == len_q - CNT_ONE);
    assign mem_rd_en   = (state_q == ST_ACTIVE) && (issued_q < len_q) && room;
    // Natural ADDR_WIDTH-bit overflow gives the wrap to address 0.
    assign mem_rd_addr = base_q + issued_q[ADDR_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            infl_q      <= mem_rd_en;
            infl_last_q <= mem_rd_en && is_last_rd;
            if (mem_rd_en) begin
                issued_q <= issued_q + CNT_ONE;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        base_q   <= start_addr;
                        len_q    <= burst_len;
                        issued_q <= '0;
                        state_q  <= (burst_len == '0) ? ST_DONE : ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    // Every read has drained once the tagged beat leaves.
                    if (pop && head[DATA_WIDTH]) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

    rd_skid_buffer #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (infl_q),
        .push_data_i ({infl_last_q, mem_rd_data}),
        .pop_i       (pop),
        .occ_o       (occ),
        .valid_o     (buf_valid),
        .head_o      (head)
    );

    assign out_valid = buf_valid;
    assign out_data  = head[DATA_WIDTH-1:0];
    assign out_last  = head[DATA_WIDTH];

endmodule

// File: tb/tb_burst_mem_reader.sv
module tb_burst_mem_reader;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   burst_len = '0;
    logic          busy, done, mem_rd_en, out_valid, out_last;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;

    logic [DW-1:0] mem [DEPTH];

    int checks = 0;
    int failures = 0;

    burst_mem_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_addr  (start_addr),
        .burst_len   (burst_len),
        .busy        (busy),
        .done        (done),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last)
    );

    always #5 clk = ~clk;

    // Memory behaviour: synchronous read, one cycle of latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    task automatic check_all_zero(input string nm);
        checks++;
        if ({busy, done, mem_rd_en, out_valid, out_last} !== 5'b0 ||
            mem_rd_addr !== '0 || out_data !== '0) begin
            failures++;
            $display("FAIL %s: busy=%b done=%b rd_en=%b addr=%h valid=%b data=%h last=%b, want all 0",
                     nm, busy, done, mem_rd_en, mem_rd_addr, out_valid, out_data, out_last);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start      = 1'($urandom);
            start_addr = AW'($urandom);
            burst_len  = (AW+1)'($urandom);
            out_ready  = 1'($urandom);
            #1 check_all_zero("reset_hold");
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (busy !== 1'b0 || mem_rd_en !== 1'b0 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_release: busy=%b rd_en=%b valid=%b, want 0 0 0",
                         busy, mem_rd_en, out_valid);
            end
        end
    endtask

    task automatic test_basic();
        logic          e_en, e_v, e_last;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        for (int a = 0; a < DEPTH; a++) mem[a] = 32'h1000 + a;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1; start_addr = 10'd5; burst_len = 11'd4;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            #1;
            e_en   = (c >= 1 && c <= 4);
            e_addr = AW'(5 + c - 1);
            e_v    = (c >= 3 && c <= 6);
            e_data = DW'(32'h1005 + c - 3);
            e_last = (c == 6);
            checks++;
            if (mem_rd_en !== e_en || (e_en && mem_rd_addr !== e_addr)) begin
                failures++;
                $display("FAIL basic_rd c=%0d: en=%b addr=%0d, want en=%b addr=%0d",
                         c, mem_rd_en, mem_rd_addr, e_en, e_addr);
            end
            checks++;
            if (out_valid !== e_v || (e_v && (out_data !== e_data || out_last !== e_last))) begin
                failures++;
                $display("FAIL basic_beat c=%0d: valid=%b data=%h last=%b, want valid=%b data=%h last=%b",
                         c, out_valid, out_data, out_last, e_v, e_data, e_last);
            end
            checks++;
            if (done !== (c == 7) || busy !== (c <= 7)) begin
                failures++;
                $display("FAIL basic_status c=%0d: done=%b busy=%b, want done=%b busy=%b",
                         c, done, busy, c == 7, c <= 7);
            end
        end
    endtask

    // mode 0: ready always, 1: random ready, 2: ready low in cycles 4..9
    task automatic run_burst(input string nm, input int addr, input int len,
                             input int mode, input bit inject);
        logic [AW-1:0] exp_a[$];
        logic [DW-1:0] exp_d[$];
        int beats = 0, reads = 0, c = 0, last_c = -1, done_c = -1;
        bit stall = 0;
        logic [DW-1:0] s_data = '0;
        logic s_last = 1'b0;
        for (int i = 0; i < len; i++) begin
            exp_a.push_back(AW'((addr + i) % DEPTH));
            exp_d.push_back(mem[(addr + i) % DEPTH]);
        end
        @(negedge clk);
        start = 1'b1; start_addr = AW'(addr); burst_len = (AW+1)'(len); out_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; start_addr = AW'($urandom); burst_len = (AW+1)'($urandom);
        while (done_c < 0 && c < 4 * len + 40) begin
            @(negedge clk);
            c++;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = !(c >= 4 && c <= 9);
            endcase
            if (inject && c == 2) begin
                start = 1'b1; start_addr = AW'($urandom); burst_len = (AW+1)'($urandom_range(1, DEPTH));
            end else begin
                start = 1'b0;
            end
            #1;
            if (mem_rd_en) begin
                checks++;
                if (reads >= len || mem_rd_addr !== exp_a[reads]) begin
                    failures++;
                    $display("FAIL %s read %0d: addr=%0d, want %0d (len %0d)",
                             nm, reads, mem_rd_addr, reads < len ? exp_a[reads] : '0, len);
                end
                reads++;
            end
            if (stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== s_data || out_last !== s_last) begin
                    failures++;
                    $display("FAIL %s stall c=%0d: valid=%b data=%h last=%b, want 1 %h %b",
                             nm, c, out_valid, out_data, out_last, s_data, s_last);
                end
            end
            stall  = out_valid && !out_ready;
            s_data = out_data;
            s_last = out_last;
            if (out_valid && out_ready) begin
                checks++;
                if (beats >= len || out_data !== exp_d[beats] || out_last !== (beats == len - 1)) begin
                    failures++;
                    $display("FAIL %s beat %0d: data=%h last=%b, want %h %b",
                             nm, beats, out_data, out_last,
                             beats < len ? exp_d[beats] : '0, beats == len - 1);
                end
                beats++;
                last_c = c;
            end
            checks++;
            if (reads - beats > 2) begin
                failures++;
                $display("FAIL %s credit c=%0d: outstanding=%0d, want <=2", nm, c, reads - beats);
            end
            if (done === 1'b1) done_c = c;
            else begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL %s busy c=%0d: got %b want 1", nm, c, busy);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (done_c < 0 || beats != len || reads != len) begin
            failures++;
            $display("FAIL %s totals: done_c=%0d beats=%0d reads=%0d, want done, %0d beats/reads",
                     nm, done_c, beats, reads, len);
        end
        checks++;
        if (done_c != last_c + 1 || (mode == 0 && last_c != len + 2)) begin
            failures++;
            $display("FAIL %s timing: last beat c=%0d done c=%0d, want done=last+1 (last=%0d if ready)",
                     nm, last_c, done_c, len + 2);
        end
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_after: busy=%b done=%b valid=%b, want 0 0 0",
                     nm, busy, done, out_valid);
        end
    endtask

    task automatic test_zero_len();
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1; start_addr = AW'($urandom); burst_len = '0;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (done !== (c == 1) || busy !== (c == 1) || mem_rd_en !== 1'b0 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL zero_len c=%0d: done=%b busy=%b rd_en=%b valid=%b, want %b %b 0 0",
                         c, done, busy, mem_rd_en, out_valid, c == 1, c == 1);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1; start_addr = AW'($urandom); burst_len = 11'd6;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);   // cycle 4: second beat on the bus
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre: valid=%b want 1", out_valid);
        end
        rst_n = 1'b0;
        #1 check_all_zero("midrst_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0 || mem_rd_en !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL midrst_after c=%0d: valid=%b rd_en=%b busy=%b, want 0 0 0",
                         c, out_valid, mem_rd_en, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        run_burst("wrap", 1022, 4, 0, 1'b0);
        for (int a = 0; a < DEPTH; a++) mem[a] = $urandom;
        run_burst("backpressure", int'($urandom_range(0, DEPTH - 1)), 8, 2, 1'b0);
        test_zero_len();
        run_burst("ignored_start", int'($urandom_range(0, DEPTH - 1)), 12, 1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run_burst("random", int'($urandom_range(0, DEPTH - 1)),
                      int'($urandom_range(1, 40)), 1, 1'b0);
        end
        run_burst("single", int'($urandom_range(0, DEPTH - 1)), 1, 0, 1'b0);
        run_burst("full_depth", int'($urandom_range(0, DEPTH - 1)), DEPTH, 1, 1'b0);
        test_reset_mid_burst();
        run_burst("after_reset", int'($urandom_range(0, DEPTH - 1)), 5, 0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
